// File: rtl/button_debouncer_pkg.sv
// rtl/button_debouncer_pkg.sv - shared FSM state type and 50 MHz default timing for the button debouncer
package button_pkg;

    typedef enum logic [1:0] {
        RELEASED,
        CONFIRM_PRESS,
        PRESSED,
        CONFIRM_RELEASE
    } btn_state_t;

    localparam int DEFAULT_DEBOUNCE_CYCLES   = 500_000;
    localparam int DEFAULT_LONG_PRESS_CYCLES = 50_000_000;
    localparam int DEFAULT_CNT_WIDTH         = 26;

endpackage

// File: rtl/button_debouncer_if.sv
// rtl/button_debouncer_if.sv - raw pin in, debounced level and strobes out
interface button_debouncer_if;

    logic btn_raw;
    logic btn_level;
    logic btn_press;
    logic btn_release;
    logic btn_long;

    modport master (
        output btn_raw,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  btn_long
    );

    modport slave (
        input  btn_raw,
        output btn_level,
        output btn_press,
        output btn_release,
        output btn_long
    );

endinterface

// File: rtl/button_debouncer_sync.sv
// rtl/button_debouncer_sync.sv - 2-flop pin synchroniser with polarity normalisation (1 = pressed)
module button_sync #(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic pressed
);

    // Flops come out of reset at the released pin level so no false press is seen.
    localparam logic IDLE_LEVEL = ACTIVE_LOW;

    logic meta;
    logic stable;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta   <= IDLE_LEVEL;
            stable <= IDLE_LEVEL;
        end else begin
            meta   <= btn_raw;
            stable <= meta;
        end
    end

    assign pressed = stable ^ ACTIVE_LOW;

endmodule

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - confirm-counter debouncer producing a clean level plus press/release/long strobes
module button_debouncer
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
    parameter int LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES,
    parameter int CNT_WIDTH         = DEFAULT_CNT_WIDTH,
    parameter bit ACTIVE_LOW        = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    button_debouncer_if.slave   bus
);

    localparam logic [CNT_WIDTH-1:0] DCNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] LCNT_LAST = CNT_WIDTH'(LONG_PRESS_CYCLES - 1);
    localparam bit                   LONG_EN   = (LONG_PRESS_CYCLES != 0);

    logic                 s;
    btn_state_t           state, state_next;
    logic [CNT_WIDTH-1:0] dcnt, dcnt_next;
    logic [CNT_WIDTH-1:0] lcnt, lcnt_next;
    logic                 long_done, long_done_next;
    logic                 level_q, level_next;
    logic                 press_q, press_next;
    logic                 release_q, release_next;
    logic                 long_q, long_next;
    logic [CNT_WIDTH-1:0] lcnt_inc;
    logic                 long_hit;

    button_sync #(
        .ACTIVE_LOW (ACTIVE_LOW)
    ) u_sync (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (bus.btn_raw),
        .pressed (s)
    );

    assign lcnt_inc = (lcnt == '1) ? lcnt : lcnt + 1'b1;
    assign long_hit = LONG_EN && !long_done && (lcnt == LCNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= RELEASED;
            dcnt      <= '0;
            lcnt      <= '0;
            long_done <= 1'b0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            state     <= state_next;
            dcnt      <= dcnt_next;
            lcnt      <= lcnt_next;
            long_done <= long_done_next;
            level_q   <= level_next;
            press_q   <= press_next;
            release_q <= release_next;
            long_q    <= long_next;
        end
    end

    always_comb begin
        state_next     = state;
        dcnt_next      = dcnt;
        lcnt_next      = lcnt;
        long_done_next = long_done;
        level_next     = level_q;
        press_next     = 1'b0;
        release_next   = 1'b0;
        long_next      = 1'b0;

        case (state)
            RELEASED: begin
                level_next = 1'b0;
                if (s) begin
                    state_next = CONFIRM_PRESS;
                    dcnt_next  = '0;
                end
            end
            CONFIRM_PRESS: begin
                level_next = 1'b0;
                if (!s) begin
                    state_next = RELEASED;
                end else if (dcnt == DCNT_LAST) begin
                    state_next     = PRESSED;
                    level_next     = 1'b1;
                    press_next     = 1'b1;
                    lcnt_next      = '0;
                    long_done_next = 1'b0;
                end else begin
                    dcnt_next = dcnt + 1'b1;
                end
            end
            PRESSED: begin
                level_next = 1'b1;
                lcnt_next  = lcnt_inc;
                if (!s) begin
                    state_next = CONFIRM_RELEASE;
                    dcnt_next  = '0;
                end
            end
            CONFIRM_RELEASE: begin
                level_next = 1'b1;
                lcnt_next  = lcnt_inc;
                if (s) begin
                    // Bounce back to pressed keeps the hold timer running.
                    state_next = PRESSED;
                    dcnt_next  = '0;
                end else if (dcnt == DCNT_LAST) begin
                    state_next   = RELEASED;
                    level_next   = 1'b0;
                    release_next = 1'b1;
                end else begin
                    dcnt_next = dcnt + 1'b1;
                end
            end
            default: begin
                state_next = RELEASED;
                level_next = 1'b0;
            end
        endcase

        // Long strobe is suppressed on the releasing edge so it never coincides with level 0.
        if ((state == PRESSED || state == CONFIRM_RELEASE) && long_hit && !release_next) begin
            long_next      = 1'b1;
            long_done_next = 1'b1;
        end
    end

    assign bus.btn_level   = level_q;
    assign bus.btn_press   = press_q;
    assign bus.btn_release = release_q;
    assign bus.btn_long    = long_q;

endmodule

// File: tb/tb_button_debouncer.sv
// tb/tb_button_debouncer.sv - directed and randomized checks of button_debouncer against a run-length reference model
module tb_button_debouncer;

    localparam int D = 4;
    localparam int L = 10;

    logic clk;
    logic reset;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    button_debouncer_if bus();

    button_debouncer #(
        .DEBOUNCE_CYCLES   (D),
        .LONG_PRESS_CYCLES (L),
        .CNT_WIDTH         (8),
        .ACTIVE_LOW        (1'b1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: level flips once s has disagreed with it for D+1 consecutive edges.
    int edge_n;
    bit m_s1, m_s2;
    bit m_level, m_press, m_release, m_long, m_long_fired;
    int m_run, m_press_edge;

    int n_press, n_release, n_long;
    int press_at, release_at, long_at;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d edge=%0d", tag, obs, exp, edge_n);
        end
    endtask

    task automatic model_reset();
        edge_n       = 0;
        m_s1         = 1'b0;
        m_s2         = 1'b0;
        m_level      = 1'b0;
        m_press      = 1'b0;
        m_release    = 1'b0;
        m_long       = 1'b0;
        m_long_fired = 1'b0;
        m_run        = 0;
        m_press_edge = -1000;
        n_press      = 0;
        n_release    = 0;
        n_long       = 0;
        press_at     = -1;
        release_at   = -1;
        long_at      = -1;
    endtask

    task automatic model_edge(input bit raw_pressed);
        bit s;
        s      = m_s2;
        m_s2   = m_s1;
        m_s1   = raw_pressed;
        edge_n = edge_n + 1;
        m_press   = 1'b0;
        m_release = 1'b0;
        m_long    = 1'b0;
        if (s != m_level) m_run = m_run + 1;
        else              m_run = 0;
        if (m_run == D + 1) begin
            m_run   = 0;
            m_level = s;
            if (s) begin
                m_press      = 1'b1;
                m_press_edge = edge_n;
                m_long_fired = 1'b0;
            end else begin
                m_release = 1'b1;
            end
        end
        if (L != 0 && m_level && !m_press && !m_long_fired && (edge_n - m_press_edge) == L) begin
            m_long       = 1'b1;
            m_long_fired = 1'b1;
        end
    endtask

    task automatic tick(input logic raw);
        bus.btn_raw = raw;
        @(posedge clk);
        model_edge(!raw);
        #1;
        check("level",   bus.btn_level,   m_level);
        check("press",   bus.btn_press,   m_press);
        check("release", bus.btn_release, m_release);
        check("long",    bus.btn_long,    m_long);
        check("press_and_release", bus.btn_press & bus.btn_release, 1'b0);
        check("long_while_released", bus.btn_long & ~bus.btn_level, 1'b0);
        if (bus.btn_press === 1'b1)   begin n_press++;   press_at   = edge_n; end
        if (bus.btn_release === 1'b1) begin n_release++; release_at = edge_n; end
        if (bus.btn_long === 1'b1)    begin n_long++;    long_at    = edge_n; end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_level",   bus.btn_level,   1'b0);
        check("rst_press",   bus.btn_press,   1'b0);
        check("rst_release", bus.btn_release, 1'b0);
        check("rst_long",    bus.btn_long,    1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        int rise_edge;
        reset       = 1'b1;
        bus.btn_raw = 1'b1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check("por_level",   bus.btn_level,   1'b0);
        check("por_press",   bus.btn_press,   1'b0);
        check("por_release", bus.btn_release, 1'b0);
        check("por_long",    bus.btn_long,    1'b0);
        reset = 1'b0;

        // Clean press held long enough for the long strobe.
        for (int i = 0; i < 30; i++) tick(1'b0);
        check("clean_press_edge", press_at, 7);
        check("clean_press_count", n_press, 1);
        check("long_edge", long_at, 17);
        check("long_count", n_long, 1);

        // Release with bounce: high 2, low 1, then high and held.
        tick(1'b1);
        tick(1'b1);
        tick(1'b0);
        rise_edge = edge_n + 1;
        for (int i = 0; i < 12; i++) tick(1'b1);
        check("release_count", n_release, 1);
        check("release_edge", release_at, rise_edge + 6);
        check("release_level", bus.btn_level, 1'b0);

        // Bounce shorter than the confirm window is rejected.
        n_press   = 0;
        n_release = 0;
        for (int i = 0; i < 3; i++) tick(1'b0);
        tick(1'b1);
        for (int i = 0; i < 3; i++) tick(1'b0);
        for (int i = 0; i < 10; i++) tick(1'b1);
        check("bounce_press_count", n_press, 0);
        check("bounce_release_count", n_release, 0);

        // Release glitch in the middle of a hold must not restart the long timer.
        apply_reset();
        for (int i = 1; i <= 30; i++) tick(i == 12);
        check("glitch_press_edge", press_at, 7);
        check("glitch_long_delay", long_at - press_at, L);
        check("glitch_long_count", n_long, 1);
        check("glitch_release_count", n_release, 0);

        // Reset while confirming a press; held button needs the full latency again.
        apply_reset();
        for (int i = 0; i < 4; i++) tick(1'b0);
        apply_reset();
        for (int i = 0; i < 10; i++) tick(1'b0);
        check("rst_mid_press_edge", press_at, 7);
        check("rst_mid_press_count", n_press, 1);

        // Randomized runs of bounce and hold.
        apply_reset();
        for (int r = 0; r < 80; r++) begin
            logic v;
            int   len;
            v   = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(8, 16)) : int'($urandom_range(1, 6));
            for (int k = 0; k < len; k++) tick(v);
        end
        for (int i = 0; i < 10; i++) tick(1'b1);
        check("random_final_level", bus.btn_level, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
